// File: rtl/dmem_pkg.sv
// dmem_arbiter shared types and constants.
// FSM state encoding, requester ids and default widths.
package dmem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int MEM_DEPTH  = 1024;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS_A,
    ACCESS_B,
    LOCK_A,
    LOCK_B
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bus of dmem_arbiter.
// Lock inputs exist only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

`ifdef DMEM_ARB_LOCK_EN
  logic              a_lock;
  logic              b_lock;

  modport master (
    output a_req, a_we, a_addr, a_wdata, a_lock,
    input  a_ack, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata, b_lock,
    input  b_ack, b_rvalid, b_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, a_lock,
    output a_ack, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata, b_lock,
    output b_ack, b_rvalid, b_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );
`else
  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rvalid, b_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rvalid, b_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );
`endif

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: two-way round-robin picker.
// A lone request wins; on a tie the pointer side wins.
module rr_pick2
  import dmem_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       gnt_o,
  output logic       valid_o
);

  // Pick the single requester, or the favoured one on a tie.
  always_comb begin
    valid_o = |req_i;
    gnt_o   = ptr_i;
    unique case (1'b1)
      (req_i == 2'b01): gnt_o = REQ_A;
      (req_i == 2'b10): gnt_o = REQ_B;
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin A/B sequencer for the data memory.
// Define DMEM_ARB_LOCK_EN to add a_lock/b_lock and LOCK states.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic           clk,
  input logic           reset_n,
  dmem_arbiter_if.slave bus
);

  state_e            state_q;
  state_e            state_d;
  logic              ptr_q;
  logic              gnt;
  logic              gnt_v;
  logic              a_ack_q;
  logic              b_ack_q;
  logic              a_rvalid_q;
  logic              b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;

  rr_pick2 u_pick (
    .req_i   ({bus.b_req, bus.a_req}),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .valid_o (gnt_v)
  );

  // Next-state: grant from IDLE, hand over or release after ACCESS.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_v)
          state_d = (gnt == REQ_A) ? ACCESS_A : ACCESS_B;
      end
      ACCESS_A: begin
        state_d = bus.b_req ? ACCESS_B : IDLE;
`ifdef DMEM_ARB_LOCK_EN
        if (bus.a_lock)
          state_d = LOCK_A;
`endif
      end
      ACCESS_B: begin
        state_d = bus.a_req ? ACCESS_A : IDLE;
`ifdef DMEM_ARB_LOCK_EN
        if (bus.b_lock)
          state_d = LOCK_B;
`endif
      end
`ifdef DMEM_ARB_LOCK_EN
      LOCK_A: begin
        if (bus.a_req)
          state_d = ACCESS_A;
        else if (!bus.a_lock)
          state_d = IDLE;
      end
      LOCK_B: begin
        if (bus.b_req)
          state_d = ACCESS_B;
        else if (!bus.b_lock)
          state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= REQ_A;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      a_ack_q <= (state_d == ACCESS_A);
      b_ack_q <= (state_d == ACCESS_B);
      unique case (state_d)
        ACCESS_A: begin
          mem_addr_q  <= bus.a_addr;
          mem_we_q    <= bus.a_we;
          mem_wdata_q <= bus.a_wdata;
        end
        ACCESS_B: begin
          mem_addr_q  <= bus.b_addr;
          mem_we_q    <= bus.b_we;
          mem_wdata_q <= bus.b_wdata;
        end
        default: begin
          mem_addr_q  <= '0;
          mem_we_q    <= 1'b0;
          mem_wdata_q <= '0;
        end
      endcase
      a_rvalid_q <= (state_q == ACCESS_A) && !mem_we_q;
      b_rvalid_q <= (state_q == ACCESS_B) && !mem_we_q;
      if ((state_q == ACCESS_A) && !mem_we_q)
        a_rdata_q <= bus.mem_rdata;
      if ((state_q == ACCESS_B) && !mem_we_q)
        b_rdata_q <= bus.mem_rdata;
      if (state_q == ACCESS_A)
        ptr_q <= REQ_B;
      else if (state_q == ACCESS_B)
        ptr_q <= REQ_A;
    end
  end

  assign bus.a_ack     = a_ack_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.a_rvalid  = a_rvalid_q;
  assign bus.b_rvalid  = b_rvalid_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  // No write may land while reset is held, even mid-access.
  assign bus.mem_we    = mem_we_q & reset_n;

  a_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (bus.a_req && !bus.a_ack) |=>
      (!bus.a_req || $stable({bus.a_we, bus.a_addr, bus.a_wdata})))
    else $error("a request fields changed before ack");

  b_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (bus.b_req && !bus.b_ack) |=>
      (!bus.b_req || $stable({bus.b_we, bus.b_addr, bus.b_wdata})))
    else $error("b request fields changed before ack");

  ack_excl: assert property (@(posedge clk)
    !(bus.a_ack && bus.b_ack))
    else $error("both acks high");

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, directed sequences,
// then random traffic against a transaction-level model.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] K  = 32'h12345678;
  localparam logic [31:0] BD = 32'hBAD0BAD0;
  localparam logic [31:0] M3 = 32'h33333333;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [DW-1:0] phys [0:1023];
  assign bus.mem_rdata = phys[bus.mem_addr[9:0]];
  always @(posedge clk)
    if (bus.mem_we) phys[bus.mem_addr[9:0]] <= bus.mem_wdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(logic ar, logic aw, logic [31:0] aa, logic [31:0] ad,
                     logic br, logic bw, logic [31:0] ba, logic [31:0] bd);
    bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
    bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic rst;
    logic ar, aw; logic [31:0] aa, ad;
    logic br, bw; logic [31:0] ba, bd;
    logic eaa, eba, earv, ebrv, emwe;
    logic [31:0] ard, brd;
  } vec_t;

  function automatic vec_t v(logic rst,
      logic ar, logic aw, logic [31:0] aa, logic [31:0] ad,
      logic br, logic bw, logic [31:0] ba, logic [31:0] bd,
      logic eaa, logic eba, logic earv, logic ebrv, logic emwe,
      logic [31:0] ard, logic [31:0] brd);
    vec_t r;
    r.rst = rst;
    r.ar = ar; r.aw = aw; r.aa = aa; r.ad = ad;
    r.br = br; r.bw = bw; r.ba = ba; r.bd = bd;
    r.eaa = eaa; r.eba = eba; r.earv = earv; r.ebrv = ebrv;
    r.emwe = emwe; r.ard = ard; r.brd = brd;
    return r;
  endfunction

  vec_t tab [15];

  // random-phase model state
  int          g;
  int          turn;
  logic [31:0] mmem [0:1023];
  logic        erv [2];
  logic [31:0] erd [2];
  logic        rq [2];
  logic        rw [2];
  logic [31:0] ra [2];
  logic [31:0] rd [2];
  logic        done [2];

  task automatic put();
    drv(rq[0], rw[0], ra[0], rd[0], rq[1], rw[1], ra[1], rd[1]);
  endtask

  task automatic newreq(int x);
    rq[x] = 1'b1;
    rw[x] = 1'($urandom_range(0, 1));
    ra[x] = $urandom_range(0, 15);
    rd[x] = $urandom;
  endtask

  initial begin
    int na, nb, ng;
    logic [31:0] ea, ew;
    logic        ewe;

    for (int i = 0; i < 1024; i++) phys[i] <= 32'h0100_0000 + i;
    phys[5] <= DB;
    phys[3] <= M3;
`ifdef DMEM_ARB_LOCK_EN
    bus.a_lock = 1'b0;
    bus.b_lock = 1'b0;
`endif
    drv(0, 0, 0, 0, 0, 0, 0, 0);

    //      rst ar aw aa  ad  br bw ba  bd  aA bA aV bV we ard brd
    tab[0]  = v(0, 0,0,0, 0, 0,0,0, 0,  0,0,0,0,0, 0, 0);
    tab[1]  = v(1, 1,0,5, 0, 0,0,0, 0,  1,0,0,0,0, 0, 0);
    tab[2]  = v(1, 1,0,5, 0, 0,0,0, 0,  0,0,1,0,0, DB,0);
    tab[3]  = v(0, 0,0,0, 0, 0,0,0, 0,  0,0,0,0,0, 0, 0);
    tab[4]  = v(1, 1,0,5, 0, 1,1,10,K,  1,0,0,0,0, 0, 0);
    tab[5]  = v(1, 1,0,5, 0, 1,1,10,K,  0,1,1,0,1, DB,0);
    tab[6]  = v(1, 0,0,0, 0, 1,1,10,K,  0,0,0,0,0, DB,0);
    tab[7]  = v(1, 1,0,10,0, 0,0,0, 0,  1,0,0,0,0, DB,0);
    tab[8]  = v(1, 1,0,10,0, 0,0,0, 0,  0,0,1,0,0, K, 0);
    tab[9]  = v(1, 1,0,5, 0, 1,0,10,0,  0,1,0,0,0, K, 0);
    tab[10] = v(1, 1,0,5, 0, 1,0,10,0,  1,0,0,1,0, K, K);
    tab[11] = v(1, 1,0,5, 0, 0,0,0, 0,  0,0,1,0,0, DB,K);
    tab[12] = v(1, 0,0,0, 0, 1,1,3, BD, 0,1,0,0,1, DB,K);
    tab[13] = v(0, 0,0,0, 0, 1,1,3, BD, 0,0,0,0,0, 0, 0);
    tab[14] = v(1, 0,0,0, 0, 0,0,0, 0,  0,0,0,0,0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      reset_n = tab[i].rst;
      drv(tab[i].ar, tab[i].aw, tab[i].aa, tab[i].ad,
          tab[i].br, tab[i].bw, tab[i].ba, tab[i].bd);
      step();
      chk($sformatf("v%0d a_ack", i), bus.a_ack, tab[i].eaa);
      chk($sformatf("v%0d b_ack", i), bus.b_ack, tab[i].eba);
      chk($sformatf("v%0d a_rvalid", i), bus.a_rvalid, tab[i].earv);
      chk($sformatf("v%0d b_rvalid", i), bus.b_rvalid, tab[i].ebrv);
      chk($sformatf("v%0d mem_we", i), bus.mem_we, tab[i].emwe);
      chk($sformatf("v%0d a_rdata", i), bus.a_rdata, tab[i].ard);
      chk($sformatf("v%0d b_rdata", i), bus.b_rdata, tab[i].brd);
    end
    chk("reset blocks write mem3", phys[3], M3);
    chk("b write mem10", phys[10], K);

    // sustained two-sided contention alternates A,B with no gaps
    do_reset();
    drv(1, 0, 1, 0, 1, 0, 2, 0);
    na = 0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("alt%0d a_ack", i), bus.a_ack, 1'((i % 2) == 0));
      chk($sformatf("alt%0d b_ack", i), bus.b_ack, 1'((i % 2) == 1));
      na += int'(bus.a_ack);
      nb += int'(bus.b_ack);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("alt count a", na, 10);
    chk("alt count b", nb, 10);

`ifdef DMEM_ARB_LOCK_EN
    // A holds a lock across three reads while B waits
    do_reset();
    drv(0, 0, 0, 0, 1, 0, 2, 0);
    for (int r = 0; r < 3; r++) begin
      bus.a_req = 1'b1; bus.a_addr = r; bus.a_lock = (r < 2);
      step();
      chk($sformatf("lock%0d a_ack", r), bus.a_ack, 1'b1);
      chk($sformatf("lock%0d b_ack", r), bus.b_ack, 1'b0);
      if (r < 2) begin
        step();
        chk($sformatf("lock%0d hold b_ack", r), bus.b_ack, 1'b0);
        bus.a_req = 1'b0;
        step();
        chk($sformatf("lock%0d wait b_ack", r), bus.b_ack, 1'b0);
        chk($sformatf("lock%0d wait a_ack", r), bus.a_ack, 1'b0);
      end
    end
    step();
    chk("lock release b_ack", bus.b_ack, 1'b1);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step();
`endif

    // random traffic against the transaction-level model
    for (int x = 0; x < 2; x++) begin
      rq[x] = 0; rw[x] = 0; ra[x] = 0; rd[x] = 0; done[x] = 0;
      erv[x] = 0; erd[x] = 0;
    end
    do_reset();
    for (int i = 0; i < 1024; i++) mmem[i] = phys[i];
    g = -1;
    turn = 0;
    put();
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      erv[0] = 1'b0;
      erv[1] = 1'b0;
      ng = -1;
      if (g >= 0) begin
        if (rw[g]) mmem[ra[g][9:0]] = rd[g];
        else begin
          erd[g] = mmem[ra[g][9:0]];
          erv[g] = 1'b1;
        end
        turn = 1 - g;
        if (rq[1 - g]) ng = 1 - g;
      end else if (rq[0] && rq[1]) ng = turn;
      else if (rq[0]) ng = 0;
      else if (rq[1]) ng = 1;
      g = ng;
      @(negedge clk);
      ea = 0; ew = 0; ewe = 0;
      if (g >= 0) begin
        ea = ra[g]; ew = rd[g]; ewe = rw[g];
      end
      chk("rnd a_ack", bus.a_ack, 1'(g == 0));
      chk("rnd b_ack", bus.b_ack, 1'(g == 1));
      chk("rnd a_rvalid", bus.a_rvalid, erv[0]);
      chk("rnd b_rvalid", bus.b_rvalid, erv[1]);
      chk("rnd a_rdata", bus.a_rdata, erd[0]);
      chk("rnd b_rdata", bus.b_rdata, erd[1]);
      chk("rnd mem_we", bus.mem_we, ewe);
      chk("rnd mem_addr", bus.mem_addr, ea);
      chk("rnd mem_wdata", bus.mem_wdata, ew);
      for (int x = 0; x < 2; x++) begin
        if (g == x) done[x] = 1'b1;
        else if (done[x]) begin
          done[x] = 1'b0;
          if ($urandom_range(0, 1) == 1) newreq(x);
          else rq[x] = 1'b0;
        end else if (!rq[x] && $urandom_range(0, 9) < 4) newreq(x);
      end
      put();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
